// File: rtl/uart_rx_fifo_if.sv
// Consumer-facing bundle of the UART receiver: serial line, pop handshake,
// error clear and the FIFO/status outputs.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          i_rx_data;
  logic                          i_rx_ready;
  logic                          i_clear_err;
  logic                          o_rx_active;
  logic [DATA_BITS-1:0]          o_byte_out;
  logic                          o_data_valid;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;
  logic                          o_frame_err;
  logic                          o_parity_err;
  logic                          o_overrun;

  modport slave (
    input  i_rx_data, i_rx_ready, i_clear_err,
    output o_rx_active, o_byte_out, o_data_valid, o_fifo_count,
           o_frame_err, o_parity_err, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_ready, i_clear_err,
    input  o_rx_active, o_byte_out, o_data_valid, o_fifo_count,
           o_frame_err, o_parity_err, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, sticky error flags and a
// show-ahead receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int BAUD_MULT  = 1666,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_uart_clk,
  input  logic           i_reset,
  uart_rx_fifo_if.slave  rx_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_MULT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_MULT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_MULT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 ones_odd;
  logic                 sample_tick;

  logic                 push;
  logic                 pop;
  logic                 push_ok;
  logic                 full;
  logic                 empty;
  logic                 set_frame;
  logic                 set_parity;
  logic                 set_overrun;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  // Line idles high, so the synchroniser resets to 1 to avoid a fake start bit.
  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_if.i_rx_data;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit verdict is decided on the sample cycle itself so the byte lands
  // without waiting for the rest of the stop bit.
  always_comb begin
    sample_tick = (baud_cnt == BIT_LAST);
    ones_odd    = ^{rx_s, shreg};
    push        = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    if (state == S_STOP && sample_tick) begin
      if (!rx_s) begin
        set_frame = 1'b1;
      end else if (stop_idx == STOP_LAST) begin
        if (par_bad) set_parity = 1'b1;
        else         push       = 1'b1;
      end
    end
  end

  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            par_bad  <= 1'b0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (sample_tick) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (sample_tick) begin
            baud_cnt <= '0;
            par_bad  <= (PARITY == 1) ? ~ones_odd : ones_odd;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (sample_tick) begin
            baud_cnt <= '0;
            if (set_frame)                   state    <= S_BREAK;
            else if (stop_idx == STOP_LAST)  state    <= S_IDLE;
            else                             stop_idx <= stop_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when the consumer is draining it.
  always_comb begin
    empty       = (count == '0);
    full        = (count == FULL_CNT);
    pop         = rx_if.i_rx_ready && !empty;
    push_ok     = push && (!full || pop);
    set_overrun = push && full && !pop;
  end

  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set takes priority over clear so an error in the clearing cycle is kept.
  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_frame   | (frame_err  & ~rx_if.i_clear_err);
      parity_err <= set_parity  | (parity_err & ~rx_if.i_clear_err);
      overrun    <= set_overrun | (overrun    & ~rx_if.i_clear_err);
    end
  end

  assign rx_if.o_rx_active  = (state != S_IDLE);
  assign rx_if.o_byte_out   = mem[rd_ptr];
  assign rx_if.o_data_valid = !empty;
  assign rx_if.o_fifo_count = count;
  assign rx_if.o_frame_err  = frame_err;
  assign rx_if.o_parity_err = parity_err;
  assign rx_if.o_overrun    = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three frame formats (8N1, 8E1, 7O2) with a
// queue scoreboard checking every popped byte.
module tb_uart_rx_fifo;

  localparam int BAUD = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] exp_c[$];

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) a_if ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b_if ();
  uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) c_if ();

  uart_rx_fifo #(.BAUD_MULT(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.i_uart_clk(clk), .i_reset(rst), .rx_if(a_if));
  uart_rx_fifo #(.BAUD_MULT(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.i_uart_clk(clk), .i_reset(rst), .rx_if(b_if));
  uart_rx_fifo #(.BAUD_MULT(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_c (.i_uart_clk(clk), .i_reset(rst), .rx_if(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Pops happen at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && a_if.o_data_valid && a_if.i_rx_ready) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sb_a_unexpected: got 0x%0h required no pop", a_if.o_byte_out);
      end else checkOutput("sb_a_pop", int'(a_if.o_byte_out), int'(exp_a.pop_front()));
    end
    if (!rst && b_if.o_data_valid && b_if.i_rx_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sb_b_unexpected: got 0x%0h required no pop", b_if.o_byte_out);
      end else checkOutput("sb_b_pop", int'(b_if.o_byte_out), int'(exp_b.pop_front()));
    end
    if (!rst && c_if.o_data_valid && c_if.i_rx_ready) begin
      if (exp_c.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sb_c_unexpected: got 0x%0h required no pop", c_if.o_byte_out);
      end else checkOutput("sb_c_pop", int'(c_if.o_byte_out), int'(exp_c.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int inst, input logic b);
    case (inst)
      0:       a_if.i_rx_data = b;
      1:       b_if.i_rx_data = b;
      default: c_if.i_rx_data = b;
    endcase
  endtask

  task automatic drive_bit(input int inst, input logic b);
    set_line(inst, b);
    wait_cycles(BAUD);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit with_par, input logic par_bit,
                            input int nstop, input logic stop_val);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(inst, data[i]);
    if (with_par) drive_bit(inst, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(inst, stop_val);
  endtask

  task automatic applyStimulus(input int inst, input logic [8:0] data, input int nbits,
                               input bit with_par, input logic par_bit,
                               input int nstop, input logic stop_val, input bit expect_push);
    if (expect_push) begin
      case (inst)
        0:       exp_a.push_back(data);
        1:       exp_b.push_back(data);
        default: exp_c.push_back(data);
      endcase
    end
    send_frame(inst, data, nbits, with_par, par_bit, nstop, stop_val);
  endtask

  task automatic pulse_ready(input int inst);
    case (inst)
      0:       a_if.i_rx_ready = 1'b1;
      1:       b_if.i_rx_ready = 1'b1;
      default: c_if.i_rx_ready = 1'b1;
    endcase
    wait_cycles(1);
    a_if.i_rx_ready = 1'b0;
    b_if.i_rx_ready = 1'b0;
    c_if.i_rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    a_if.i_clear_err = 1'b1;
    b_if.i_clear_err = 1'b1;
    c_if.i_clear_err = 1'b1;
    wait_cycles(1);
    a_if.i_clear_err = 1'b0;
    b_if.i_clear_err = 1'b0;
    c_if.i_clear_err = 1'b0;
  endtask

  task automatic check_a_reset_values(input string tag);
    checkOutput({tag, "_active"}, int'(a_if.o_rx_active), 0);
    checkOutput({tag, "_valid"},  int'(a_if.o_data_valid), 0);
    checkOutput({tag, "_count"},  int'(a_if.o_fifo_count), 0);
    checkOutput({tag, "_byte"},   int'(a_if.o_byte_out), 0);
    checkOutput({tag, "_errs"},
                int'({a_if.o_frame_err, a_if.o_parity_err, a_if.o_overrun}), 0);
  endtask

  initial begin
    bit saw_active;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.i_rx_data = 1'b1; b_if.i_rx_data = 1'b1; c_if.i_rx_data = 1'b1;
    a_if.i_rx_ready = 1'b0; b_if.i_rx_ready = 1'b0; c_if.i_rx_ready = 1'b0;
    a_if.i_clear_err = 1'b0; b_if.i_clear_err = 1'b0; c_if.i_clear_err = 1'b0;
    wait_cycles(3);
    check_a_reset_values("reset");
    rst = 1'b0;
    wait_cycles(3);

    $display("[TB] 8N1 single byte");
    applyStimulus(0, 9'h041, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(2);
    checkOutput("t1_valid", int'(a_if.o_data_valid), 1);
    checkOutput("t1_count", int'(a_if.o_fifo_count), 1);
    checkOutput("t1_byte",  int'(a_if.o_byte_out), 'h41);
    checkOutput("t1_active_idle", int'(a_if.o_rx_active), 0);
    pulse_ready(0);
    checkOutput("t1_count_after_pop", int'(a_if.o_fifo_count), 0);
    checkOutput("t1_valid_after_pop", int'(a_if.o_data_valid), 0);

    $display("[TB] even parity");
    applyStimulus(1, 9'h041, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(2);
    checkOutput("t2_count_good", int'(b_if.o_fifo_count), 1);
    checkOutput("t2_perr_good",  int'(b_if.o_parity_err), 0);
    applyStimulus(1, 9'h041, 8, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    wait_cycles(2);
    checkOutput("t2_perr_bad",  int'(b_if.o_parity_err), 1);
    checkOutput("t2_count_bad", int'(b_if.o_fifo_count), 1);
    pulse_clear();
    checkOutput("t2_perr_cleared", int'(b_if.o_parity_err), 0);
    pulse_ready(1);
    checkOutput("t2_count_drained", int'(b_if.o_fifo_count), 0);

    $display("[TB] frame error and break");
    applyStimulus(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("t3_ferr",   int'(a_if.o_frame_err), 1);
    checkOutput("t3_valid",  int'(a_if.o_data_valid), 0);
    checkOutput("t3_active", int'(a_if.o_rx_active), 1);
    pulse_clear();
    checkOutput("t3_ferr_cleared", int'(a_if.o_frame_err), 0);
    wait_cycles(20 * BAUD - 3);
    checkOutput("t3_ferr_once",        int'(a_if.o_frame_err), 0);
    checkOutput("t3_active_held_low",  int'(a_if.o_rx_active), 1);
    set_line(0, 1'b1);
    wait_cycles(4);
    checkOutput("t3_active_released", int'(a_if.o_rx_active), 0);
    checkOutput("t3_ferr_after_release", int'(a_if.o_frame_err), 0);
    wait_cycles(2);
    applyStimulus(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(2);
    checkOutput("t3_byte_after", int'(a_if.o_byte_out), 'h33);
    pulse_ready(0);
    checkOutput("t3_count_drained", int'(a_if.o_fifo_count), 0);

    $display("[TB] overrun with back-to-back frames");
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 9'(i), 8, 1'b0, 1'b0, 1, 1'b1, i <= 4);
    wait_cycles(2);
    checkOutput("t4_count",   int'(a_if.o_fifo_count), 4);
    checkOutput("t4_overrun", int'(a_if.o_overrun), 1);
    checkOutput("t4_head",    int'(a_if.o_byte_out), 'h01);
    a_if.i_rx_ready = 1'b1;
    wait_cycles(6);
    a_if.i_rx_ready = 1'b0;
    checkOutput("t4_count_drained", int'(a_if.o_fifo_count), 0);
    pulse_clear();
    checkOutput("t4_overrun_cleared", int'(a_if.o_overrun), 0);

    $display("[TB] glitch rejection");
    set_line(0, 1'b0);
    wait_cycles(1);
    set_line(0, 1'b1);
    saw_active = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_active = saw_active | a_if.o_rx_active;
    end
    checkOutput("t5_active_pulsed", int'(saw_active), 1);
    checkOutput("t5_active_back",   int'(a_if.o_rx_active), 0);
    checkOutput("t5_no_push",       int'(a_if.o_fifo_count), 0);
    checkOutput("t5_no_ferr",       int'(a_if.o_frame_err), 0);
    wait_cycles(2);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst = 1'b1;
    set_line(0, 1'b1);
    wait_cycles(2);
    exp_a.delete();
    check_a_reset_values("t6_in_reset");
    rst = 1'b0;
    wait_cycles(3);
    check_a_reset_values("t6_after_reset");
    applyStimulus(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(2);
    checkOutput("t6_count", int'(a_if.o_fifo_count), 1);
    checkOutput("t6_byte",  int'(a_if.o_byte_out), 'h7E);
    pulse_ready(0);

    $display("[TB] 7 data bits, odd parity, 2 stop bits");
    applyStimulus(2, 9'h02A, 7, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    wait_cycles(2);
    checkOutput("t7_count", int'(c_if.o_fifo_count), 1);
    checkOutput("t7_byte",  int'(c_if.o_byte_out), 'h2A);
    checkOutput("t7_perr",  int'(c_if.o_parity_err), 0);
    applyStimulus(2, 9'h02A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    wait_cycles(2);
    checkOutput("t7_perr_bad",  int'(c_if.o_parity_err), 1);
    checkOutput("t7_count_bad", int'(c_if.o_fifo_count), 1);
    pulse_ready(2);
    checkOutput("t7_count_drained", int'(c_if.o_fifo_count), 0);

    wait_cycles(2);
    checkOutput("sb_a_left", exp_a.size(), 0);
    checkOutput("sb_b_left", exp_b.size(), 0);
    checkOutput("sb_c_left", exp_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format, parity checking, error reporting and a built-in receive FIFO. It is the next-generation replacement for the single-byte `uart_rx` core. It sits between the board RX pin (`PIN_1`) and application logic. Bytes are buffered so the consumer can drain them with a valid/ready handshake instead of having to catch every byte immediately.

## Interface
- `BAUD_MULT`, 1666: clock cycles per bit. Integer ≥ 4. Simulation uses 4.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries. Power of two, ≥ 2.

Ports:
- `i_uart_clk` in 1: single clock for all logic.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_rx_data` in 1: serial line. Idles high. Asynchronous to the clock.
- `i_rx_ready` in 1: consumer ready. A pop occurs when `i_rx_ready && o_data_valid`.
- `i_clear_err` in 1: clears all sticky error flags.
- `o_rx_active` out 1: high while a frame is being received (state ≠ IDLE).
- `o_byte_out` out DATA_BITS: the FIFO head (show-ahead). Valid only when `o_data_valid` is high.
- `o_data_valid` out 1: FIFO is not empty.
- `o_fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `o_frame_err` out 1: sticky. A stop bit was sampled low.
- `o_parity_err` out 1: sticky. Parity mismatch.
- `o_overrun` out 1: sticky. A good byte arrived while the FIFO was full.

## Operation
- Input synchroniser:
  - Two flops on `i_rx_data`, both reset to 1.
  - All logic uses the synchronised line `rx_s`.
- Bit counter: counts `i_uart_clk` cycles within a bit.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when `rx_s` = 0, go to START and clear the bit counter.
  - START: after BAUD_MULT/2 cycles (integer division), sample `rx_s`.
    - If 1: false start, return to IDLE.
    - If 0: go to DATA.
  - DATA: sample every BAUD_MULT cycles, DATA_BITS samples, LSB first into a shift register. Then go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: one sample after BAUD_MULT cycles, checked against the received data.
    - Odd: the total count of 1s, including the parity bit, must be odd.
    - Even: that count must be even.
  - STOP: STOP_BITS samples, each BAUD_MULT cycles apart. Every stop sample must be 1.
    - If every stop sample is 1 and parity is OK, push the byte and go to IDLE on the cycle of the final stop sample. The block does not wait for the stop bit to end.
    - If any stop sample is 0, set `o_frame_err`, discard the byte and go to BREAK.
    - If parity failed but the stop bits are good, set `o_parity_err`, discard the byte and go to IDLE.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. A held-low line produces exactly one frame error.
- FIFO:
  - Circular buffer, FIFO_DEPTH × DATA_BITS, with read and write pointers that wrap at FIFO_DEPTH.
  - Push when full: the byte is dropped, `o_overrun` is set, and stored contents are unchanged.
  - Push and pop in the same cycle: both happen.
    - When full, the new byte is accepted and the count is unchanged.
    - When empty, there is no pop, because `o_data_valid` is low.
  - Pop when empty: ignored.
- Error flags:
  - Stay set until `i_clear_err` or reset.
  - If a set and `i_clear_err` occur in the same cycle, set wins.

## Timing
- Reset values:
  - Outputs: `o_rx_active`, `o_data_valid`, `o_frame_err`, `o_parity_err`, `o_overrun` = 0; `o_fifo_count` = 0; `o_byte_out` = 0.
  - Internal: state = IDLE, synchroniser = 1, pointers = 0.
- Input latency: 2 cycles through the synchroniser before IDLE sees a falling edge.
- `o_rx_active`: rises one cycle after the falling edge reaches `rx_s`. Falls one cycle after the final stop sample, or after BREAK exits.
- Push latency: `o_data_valid`, `o_fifo_count` and `o_byte_out` (when the FIFO was empty) update on the cycle after the final stop sample.
- Pop: a pop at edge N advances the head, so `o_byte_out` shows the next entry at N+1 and `o_fifo_count` decrements at N+1.
- Reset mid-frame: the frame is aborted, the partial byte is lost and FIFO contents are cleared.
- Back-to-back frames: a new start bit may begin immediately after the final stop sample and is detected correctly.

## Test plan
1. **8N1 byte:** BAUD_MULT=4, 8N1. Send 0x41 ('A'). Expect `o_data_valid`=1, `o_byte_out`=0x41, `o_fifo_count`=1. Pulse `i_rx_ready` for 1 cycle, then expect count 0 and valid 0.
2. **Even parity:** PARITY=2. Send 0x41 with parity bit 0: accepted. Send 0x41 with parity bit 1: `o_parity_err`=1, count unchanged. Pulse `i_clear_err`: flag returns to 0.
3. **Frame error:** 8N1. Send 0x55 with stop bit 0 and hold the line low for 20 bit times. Expect `o_frame_err`=1 exactly once, no push, `o_rx_active` high until the line returns high. Then send 0x33: received correctly.
4. **Overrun:** FIFO_DEPTH=4. Send 0x01–0x05 with `i_rx_ready`=0. Expect count 4 and `o_overrun`=1. Drain: 0x01, 0x02, 0x03, 0x04 in order.
5. **Glitch rejection:** drive the line low for 1 cycle (less than BAUD_MULT/2 after synchronisation). Expect `o_rx_active` to pulse and return to 0, and no push.
6. **Reset mid-frame:** assert `i_reset` after 3 data bits of 0xA5. All outputs read their reset values. Then send 0x7E: received correctly, count 1. Also cover 2 stop bits with 7 data bits and odd parity on 0x2A: accepted.
